// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N-channel synchronising debouncer with rise/fall strobes
module multi_debouncer #(
    parameter int CHANNELS       = 4,
    parameter int DEBOUNCE_VALUE = 100,
    parameter int COUNTER_WIDTH  = 32,
    parameter int SYNC_STAGES    = 2,
    parameter bit RESET_LEVEL    = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] line,
    output logic [CHANNELS-1:0] debounced_line,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] busy
);

    localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(DEBOUNCE_VALUE - 1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        // chain[0] is the raw line; chain[SYNC_STAGES] is the synchronised sample
        logic [SYNC_STAGES:0]     chain;
        logic [COUNTER_WIDTH-1:0] cnt;
        logic                     s;

        assign chain[0] = line[i];
        assign s        = chain[SYNC_STAGES];
        assign busy[i]  = (cnt != '0);

        always_ff @(posedge clk) begin
            if (!reset) begin
                chain[SYNC_STAGES:1] <= {SYNC_STAGES{RESET_LEVEL}};
                debounced_line[i]    <= RESET_LEVEL;
                cnt                  <= '0;
                rise[i]              <= 1'b0;
                fall[i]              <= 1'b0;
            end else begin
                chain[SYNC_STAGES:1] <= chain[SYNC_STAGES-1:0];
                rise[i]              <= 1'b0;
                fall[i]              <= 1'b0;
                if (s == debounced_line[i]) begin
                    cnt <= '0;
                end else if (cnt == LAST_COUNT) begin
                    debounced_line[i] <= s;
                    cnt               <= '0;
                    rise[i]           <= s;
                    fall[i]           <= ~s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
